// File: rtl/decode_stage.sv
// Decode stage: instruction decode, condition check, register file and one-deep output register.
// Define DECODE_WB_BYPASS_EN to forward same-cycle write-back data onto the register reads.
module decode_stage #(
  parameter int WORD_SIZE    = 32,
  parameter int ADDRESS_SIZE = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [31:0]             Instruction,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_SIZE-1:0]    Result_WB,
  input  logic                    writeBackEn,
  input  logic [ADDRESS_SIZE-1:0] Dest_wb,
  input  logic                    hazard,
  input  logic                    flush,
  input  logic [3:0]              SR,
  output logic [ADDRESS_SIZE-1:0] src1,
  output logic [ADDRESS_SIZE-1:0] src2,
  output logic                    Two_src,
  output logic                    WB_EN,
  output logic                    MEM_R_EN,
  output logic                    MEM_W_EN,
  output logic                    B,
  output logic                    S,
  output logic [3:0]              EXE_CMD,
  output logic [WORD_SIZE-1:0]    Val_Rn,
  output logic [WORD_SIZE-1:0]    Val_Rm,
  output logic                    imm,
  output logic [11:0]             Shift_operand,
  output logic [23:0]             Signed_imm_24,
  output logic [ADDRESS_SIZE-1:0] Dest,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int NumRegs = 2 ** ADDRESS_SIZE;

  logic [WORD_SIZE-1:0]    rf_q [NumRegs];
  logic [WORD_SIZE-1:0]    rn_rd, rm_rd;
  logic [1:0]              mode;
  logic [3:0]              opcode;
  logic                    dec_wb, dec_mr, dec_mw, dec_b, dec_s;
  logic [3:0]              dec_cmd;
  logic                    cond_pass;
  logic                    advance;
  logic [ADDRESS_SIZE-1:0] rd_field;

  assign mode     = Instruction[27:26];
  assign opcode   = Instruction[24:21];
  assign rd_field = ADDRESS_SIZE'(Instruction[15:12]);

  assign src1    = ADDRESS_SIZE'(Instruction[19:16]);
  assign src2    = dec_mw ? rd_field : ADDRESS_SIZE'(Instruction[3:0]);
  assign Two_src = ~Instruction[25] | dec_mw;

  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance & (flush | ~hazard);

  always_comb begin
    dec_wb  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_b   = 1'b0;
    dec_s   = 1'b0;
    dec_cmd = 4'b0000;
    unique case (mode)
      2'b00: begin
        dec_wb = 1'b1;
        dec_s  = Instruction[20];
        case (opcode)
          4'b1101: dec_cmd = 4'b0001;  // MOV
          4'b1111: dec_cmd = 4'b1001;  // MVN
          4'b0100: dec_cmd = 4'b0010;  // ADD
          4'b0101: dec_cmd = 4'b0011;  // ADC
          4'b0010: dec_cmd = 4'b0100;  // SUB
          4'b0110: dec_cmd = 4'b0101;  // SBC
          4'b0000: dec_cmd = 4'b0110;  // AND
          4'b1100: dec_cmd = 4'b0111;  // ORR
          4'b0001: dec_cmd = 4'b1000;  // EOR
          4'b1010: begin               // CMP
            dec_cmd = 4'b0100;
            dec_wb  = 1'b0;
          end
          4'b1000: begin               // TST
            dec_cmd = 4'b0110;
            dec_wb  = 1'b0;
          end
          default: begin
            dec_wb = 1'b0;
            dec_s  = 1'b0;
          end
        endcase
      end
      2'b01: begin
        dec_cmd = 4'b0010;
        dec_mr  = Instruction[20];
        dec_wb  = Instruction[20];
        dec_mw  = ~Instruction[20];
      end
      2'b10:   dec_b = 1'b1;
      default: ;
    endcase
  end

  // SR is {N,Z,C,V}
  always_comb begin
    cond_pass = 1'b0;
    case (Instruction[31:28])
      4'h0: cond_pass = SR[2];
      4'h1: cond_pass = ~SR[2];
      4'h2: cond_pass = SR[1];
      4'h3: cond_pass = ~SR[1];
      4'h4: cond_pass = SR[3];
      4'h5: cond_pass = ~SR[3];
      4'h6: cond_pass = SR[0];
      4'h7: cond_pass = ~SR[0];
      4'h8: cond_pass = SR[1] & ~SR[2];
      4'h9: cond_pass = ~SR[1] | SR[2];
      4'hA: cond_pass = (SR[3] == SR[0]);
      4'hB: cond_pass = (SR[3] != SR[0]);
      4'hC: cond_pass = ~SR[2] & (SR[3] == SR[0]);
      4'hD: cond_pass = SR[2] | (SR[3] != SR[0]);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rn_rd = (writeBackEn && (Dest_wb == src1)) ? Result_WB : rf_q[src1];
  assign rm_rd = (writeBackEn && (Dest_wb == src2)) ? Result_WB : rf_q[src2];
`else
  assign rn_rd = rf_q[src1];
  assign rm_rd = rf_q[src2];
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NumRegs; i++) begin
        rf_q[i] <= '0;
      end
    end else if (writeBackEn) begin
      rf_q[Dest_wb] <= Result_WB;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid     <= 1'b0;
      WB_EN         <= 1'b0;
      MEM_R_EN      <= 1'b0;
      MEM_W_EN      <= 1'b0;
      B             <= 1'b0;
      S             <= 1'b0;
      EXE_CMD       <= 4'b0000;
      Val_Rn        <= '0;
      Val_Rm        <= '0;
      imm           <= 1'b0;
      Shift_operand <= '0;
      Signed_imm_24 <= '0;
      Dest          <= '0;
    end else if (advance) begin
      if (flush || hazard || !in_valid) begin
        // Bubble: datapath fields keep their last value, only controls are cleared.
        out_valid <= 1'b0;
        WB_EN     <= 1'b0;
        MEM_R_EN  <= 1'b0;
        MEM_W_EN  <= 1'b0;
        B         <= 1'b0;
        S         <= 1'b0;
        EXE_CMD   <= 4'b0000;
      end else begin
        out_valid     <= 1'b1;
        WB_EN         <= dec_wb & cond_pass;
        MEM_R_EN      <= dec_mr & cond_pass;
        MEM_W_EN      <= dec_mw & cond_pass;
        B             <= dec_b & cond_pass;
        S             <= dec_s & cond_pass;
        EXE_CMD       <= cond_pass ? dec_cmd : 4'b0000;
        Val_Rn        <= rn_rd;
        Val_Rm        <= rm_rd;
        imm           <= Instruction[25];
        Shift_operand <= Instruction[11:0];
        Signed_imm_24 <= Instruction[23:0];
        Dest          <= rd_field;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, hand sequences and random traffic
// checked against a behavioural model.
module tb_decode_stage;

  logic        CLK, RST;
  logic [31:0] Instruction;
  logic        in_valid, in_ready;
  logic [31:0] Result_WB;
  logic        writeBackEn;
  logic [3:0]  Dest_wb;
  logic        hazard, flush;
  logic [3:0]  SR;
  logic [3:0]  src1, src2;
  logic        Two_src;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, B, S;
  logic [3:0]  EXE_CMD;
  logic [31:0] Val_Rn, Val_Rm;
  logic        imm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [3:0]  Dest;
  logic        out_valid, out_ready;

  decode_stage dut (
    .CLK(CLK), .RST(RST), .Instruction(Instruction), .in_valid(in_valid), .in_ready(in_ready),
    .Result_WB(Result_WB), .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .hazard(hazard),
    .flush(flush), .SR(SR), .src1(src1), .src2(src2), .Two_src(Two_src), .WB_EN(WB_EN),
    .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S(S), .EXE_CMD(EXE_CMD),
    .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm), .Shift_operand(Shift_operand),
    .Signed_imm_24(Signed_imm_24), .Dest(Dest), .out_valid(out_valid), .out_ready(out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [9:0]   dut_ctrl;
  logic [104:0] dut_data;
  assign dut_ctrl = {out_valid, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD};
  assign dut_data = {Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest};

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural model state
  logic [9:0]   m_ctrl;
  logic [104:0] m_data;
  logic [31:0]  mreg [16];
  int           dp_cmd [16];
  bit           dp_wb [16];

  task automatic model_reset();
    m_ctrl = '0;
    m_data = '0;
    for (int i = 0; i < 16; i++) mreg[i] = '0;
  endtask

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] sr);
    logic n, z, cf, v, base;
    {n, z, cf, v} = sr;
    if (c == 4'hE) return 1'b1;
    if (c == 4'hF) return 1'b0;
    case (c[3:1])
      3'd0:    base = z;
      3'd1:    base = cf;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = cf & ~z;
      3'd5:    base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return c[0] ? ~base : base;
  endfunction

  // c = {wb, mr, mw, b, s, cmd}
  task automatic model_decode(input logic [31:0] ins, input logic [3:0] sr,
                              output logic [8:0] c, output logic mwd);
    int op;
    op  = int'(ins[24:21]);
    c   = '0;
    mwd = 1'b0;
    case (ins[27:26])
      2'd0: if (dp_cmd[op] >= 0) c = {dp_wb[op], 3'b000, ins[20], 4'(dp_cmd[op])};
      2'd1: begin
        mwd = !ins[20];
        c   = {ins[20], ins[20], !ins[20], 2'b00, 4'd2};
      end
      2'd2: c = 9'h020;
      default: c = '0;
    endcase
    if (!cond_ok(ins[31:28], sr)) c = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [3:0] a);
`ifdef DECODE_WB_BYPASS_EN
    if (writeBackEn && Dest_wb == a) return Result_WB;
`endif
    return mreg[a];
  endfunction

  // Checks combinational outputs, advances the model, clocks once and checks registered outputs.
  task automatic step();
    logic [8:0] c;
    logic       mwd, adv;
    logic [3:0] s2;
    #1;
    model_decode(Instruction, SR, c, mwd);
    s2  = mwd ? Instruction[15:12] : Instruction[3:0];
    adv = !m_ctrl[9] || out_ready;
    check("src1", src1, Instruction[19:16]);
    check("src2", src2, s2);
    check("two_src", Two_src, !Instruction[25] || mwd);
    check("in_ready", in_ready, adv && (flush || !hazard));
    if (adv) begin
      if (flush || hazard || !in_valid) begin
        m_ctrl = '0;
      end else begin
        m_ctrl = {1'b1, c};
        m_data = {m_read(Instruction[19:16]), m_read(s2), Instruction[25], Instruction[11:0],
                  Instruction[23:0], Instruction[15:12]};
      end
    end
    if (writeBackEn) mreg[Dest_wb] = Result_WB;
    @(posedge CLK);
    #1;
    check("ctrl", dut_ctrl, m_ctrl);
    check("data", dut_data, m_data);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [3:0]  sr;
    logic [9:0]  ctrl;  // {out_valid, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD}
    logic [31:0] rn;
    logic [31:0] rm;
  } vec_t;

  vec_t vt [16];
  logic [31:0] exp_bypass;

  initial begin
    for (int i = 0; i < 16; i++) begin
      dp_cmd[i] = -1;
      dp_wb[i]  = 1'b1;
    end
    dp_cmd[13] = 1; dp_cmd[15] = 9; dp_cmd[4] = 2; dp_cmd[5] = 3; dp_cmd[2] = 4; dp_cmd[6] = 5;
    dp_cmd[0] = 6; dp_cmd[12] = 7; dp_cmd[1] = 8; dp_cmd[10] = 4; dp_cmd[8] = 6;
    dp_wb[10] = 1'b0;
    dp_wb[8]  = 1'b0;

    // R2=5, R3=7, every other register 0
    vt[0]  = '{32'hE0821003, 4'h0, 10'h302, 32'd5, 32'd7};  // ADD R1,R2,R3
    vt[1]  = '{32'h03A01005, 4'h0, 10'h200, 32'd0, 32'd0};  // MOVEQ, Z=0
    vt[2]  = '{32'h03A01005, 4'h4, 10'h301, 32'd0, 32'd0};  // MOVEQ, Z=1
    vt[3]  = '{32'hE0524003, 4'h0, 10'h314, 32'd5, 32'd7};  // SUBS
    vt[4]  = '{32'hE1520003, 4'h0, 10'h214, 32'd5, 32'd7};  // CMP
    vt[5]  = '{32'hE1120003, 4'h0, 10'h216, 32'd5, 32'd7};  // TST
    vt[6]  = '{32'hE0B21003, 4'h0, 10'h313, 32'd5, 32'd7};  // ADCS
    vt[7]  = '{32'hE5921004, 4'h0, 10'h382, 32'd5, 32'd0};  // LDR
    vt[8]  = '{32'hE5823000, 4'h0, 10'h242, 32'd5, 32'd7};  // STR, src2 = Rd
    vt[9]  = '{32'hEA000010, 4'h0, 10'h220, 32'd0, 32'd0};  // B
    vt[10] = '{32'hE1C21003, 4'h0, 10'h200, 32'd5, 32'd7};  // BIC: unlisted
    vt[11] = '{32'hF0821003, 4'h0, 10'h200, 32'd5, 32'd7};  // cond 1111
    vt[12] = '{32'hC0821003, 4'h0, 10'h302, 32'd5, 32'd7};  // GT true
    vt[13] = '{32'hC0821003, 4'h8, 10'h200, 32'd5, 32'd7};  // GT false (N!=V)
    vt[14] = '{32'hB0821003, 4'h8, 10'h302, 32'd5, 32'd7};  // LT true
    vt[15] = '{32'hEC000000, 4'h0, 10'h200, 32'd0, 32'd0};  // mode 11

    RST = 1'b0; Instruction = '0; in_valid = 1'b0; Result_WB = '0; writeBackEn = 1'b0;
    Dest_wb = '0; hazard = 1'b0; flush = 1'b0; SR = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset ctrl", dut_ctrl, 10'h000);
    check("reset data", dut_data, 105'h0);
    RST = 1'b1;

    // Preload R2=5, R3=7
    writeBackEn = 1'b1; Dest_wb = 4'd2; Result_WB = 32'd5;
    step();
    Dest_wb = 4'd3; Result_WB = 32'd7;
    step();
    writeBackEn = 1'b0;

    // Directed vector table
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      Instruction = vt[i].ins;
      SR = vt[i].sr;
      step();
      check($sformatf("vec%0d ctrl", i), dut_ctrl, vt[i].ctrl);
      check($sformatf("vec%0d rn", i), Val_Rn, vt[i].rn);
      check($sformatf("vec%0d rm", i), Val_Rm, vt[i].rm);
      if (i == 0) check("add dest", Dest, 4'd1);
      if (i == 1) check("moveq shift_op", Shift_operand, 12'h005);
    end

    // Hazard held for two cycles during an LDR
    SR = 4'h0; Instruction = 32'hE5921004; hazard = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("hazard in_ready", in_ready, 1'b0);
      step();
      check("hazard bubble", out_valid, 1'b0);
    end
    hazard = 1'b0;
    step();
    check("ldr after hazard", {out_valid, MEM_R_EN}, 2'b11);

    // Back-pressure then flush over hazard
    Instruction = 32'hE0821003;
    step();
    out_ready = 1'b0; Instruction = 32'hE0524003;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("stall in_ready", in_ready, 1'b0);
      step();
      check("stall hold ctrl", dut_ctrl, 10'h302);
      check("stall hold rm", Val_Rm, 32'd7);
    end
    out_ready = 1'b1; flush = 1'b1; hazard = 1'b1;
    #1;
    check("flush in_ready", in_ready, 1'b1);
    step();
    check("flush out_valid", out_valid, 1'b0);
    flush = 1'b0; hazard = 1'b0;

    // Write-back to R2 in the same cycle as a read of R2
    Instruction = 32'hE0821003;
    writeBackEn = 1'b1; Dest_wb = 4'd2; Result_WB = 32'h99;
`ifdef DECODE_WB_BYPASS_EN
    exp_bypass = 32'h99;
`else
    exp_bypass = 32'd5;
`endif
    step();
    check("same-cycle read", Val_Rn, exp_bypass);
    writeBackEn = 1'b0;
    step();
    check("next-cycle read", Val_Rn, 32'h99);

    // Asynchronous reset between edges; writes while in reset are dropped
    #2;
    RST = 1'b0;
    #1;
    check("async rst ctrl", dut_ctrl, 10'h000);
    check("async rst rn", Val_Rn, 32'd0);
    model_reset();
    writeBackEn = 1'b1; Dest_wb = 4'd2; Result_WB = 32'h55;
    @(posedge CLK);
    #1;
    RST = 1'b1; writeBackEn = 1'b0;
    step();
    check("post-reset rn", Val_Rn, 32'd0);
    check("post-reset valid", out_valid, 1'b1);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      Instruction = $urandom();
      SR          = 4'($urandom());
      in_valid    = ($urandom_range(0, 9) < 8);
      hazard      = ($urandom_range(0, 9) < 2);
      flush       = ($urandom_range(0, 9) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      writeBackEn = 1'($urandom_range(0, 1));
      Dest_wb     = 4'($urandom());
      Result_WB   = $urandom();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
